ctx_switch_ctrl: RTL and testbench
==================================

# ctx_switch_ctrl

Context-switch sequencer for the OS-lab processor register file. On a start request it streams general registers 1..63 of the running process out to a per-process save area in data memory, then streams the incoming process's save area back into registers 1..63. It owns one register-file read port, one write port and one data-memory port, and stalls the CPU while it runs.

## Interface
Parameters:
- CTX_BASE, 32'h0000_3000, word address of process 0's save area
- ID_W, 4, process-id width (16 processes)
- ADDR_W, 32, memory word-address width

Ports:
- Slow_Clock  in  1  sole clock; all state changes on posedge
- Reset  in  1  synchronous, active-high
- Start  in  1  request pulse; sampled only in IDLE
- Save_En  in  1  perform save phase (sampled with Start)
- Load_En  in  1  perform load phase (sampled with Start)
- Save_Id  in  ID_W  outgoing process id (sampled with Start)
- Load_Id  in  ID_W  incoming process id (sampled with Start)
- Rf_Read_Sel  out  6  register-file read select
- Rf_Read_Data  in  32  combinational read data for Rf_Read_Sel
- Rf_Write_En  out  1  register-file write strobe
- Rf_Write_Sel  out  6  register-file write select
- Rf_Write_Data  out  32  register-file write data
- Mem_Addr  out  ADDR_W  data-memory word address
- Mem_Write_En  out  1  memory write strobe
- Mem_Write_Data  out  32  memory write data
- Mem_Read_Data  in  32  memory read data, valid one cycle after Mem_Addr
- Busy  out  1  high in SAVE, LOAD, LOAD_TAIL
- Stall_Cpu  out  1  equals Busy
- Done  out  1  one-cycle completion pulse
- Cur_Id  out  ID_W  id of the process currently loaded

## Operation
- Save area of process p: CTX_BASE + p*64, computed as CTX_BASE + {p, 6'b0}, modulo 2^ADDR_W. Word k holds register k; word 0 is never touched.
- States: IDLE, SAVE, LOAD, LOAD_TAIL, DONE. A 6-bit index register idx sequences both phases.
- IDLE: on Start, latch Save_En, Load_En and both bases; idx <= 1. Next state is SAVE if Save_En, else LOAD if Load_En, else DONE.
- SAVE: Rf_Read_Sel = idx; Mem_Addr = save_base + idx; Mem_Write_En = 1; Mem_Write_Data = Rf_Read_Data.
  - At idx == 63: idx <= 1; next state is LOAD if Load_En, else DONE.
  - Otherwise idx++.
- LOAD: Mem_Addr = load_base + idx (read). If idx > 1, Rf_Write_En = 1, Rf_Write_Sel = idx-1, Rf_Write_Data = Mem_Read_Data.
  - At idx == 63: next state LOAD_TAIL; otherwise idx++.
- LOAD_TAIL: Rf_Write_En = 1, Rf_Write_Sel = 63, Rf_Write_Data = Mem_Read_Data.
- DONE: Done = 1 for one cycle; Cur_Id <= Load_Id_latched if Load_En; next state IDLE.
- Rf_Write_Sel is never 0. Register 0 is never read for save and never written.
- Start outside IDLE is ignored, with no queuing.
- All strobes are low in IDLE and DONE. Inactive select and address outputs drive 0.

## Timing
- Reset values: state IDLE, idx 0, all outputs 0, Cur_Id 0.
- Reset mid-operation aborts at the next edge. No strobe is asserted after that edge. Memory and register contents already written stay partially updated.
- Start sampled high at edge E0 gives this sequence:
  - SAVE occupies cycles 1..63.
  - LOAD occupies cycles 64..126.
  - LOAD_TAIL is cycle 127.
  - Done is high in cycle 128, with Busy low in that cycle.
- Save-only: Done at cycle 64. Load-only: LOAD 1..63, TAIL 64, Done 65. Neither: Done at cycle 1.
- Busy and Stall_Cpu are registered state decodes. Strobes are combinational from state and idx. A memory write lands on the same edge it is asserted.
- Start in the same cycle as Done is ignored. A new Start is accepted from IDLE, one cycle after Done at the earliest.

## Structure
- Package ctx_pkg holds:
  - state enum
  - CTX_WORDS = 64
  - FIRST_REG = 1
  - LAST_REG = 63
- Sub-module ctx_addr_gen: registered base latch plus adder producing Mem_Addr from base and idx. Everything else stays in ctx_switch_ctrl.

## Test plan
- Preload regs 1..63 with 0x100+k; Start, Save_En=1, Load_En=0, Save_Id=2 -> mem[0x3080+k] = 0x100+k for k = 1..63, mem[0x3080] unchanged, Done at cycle 64.
- Preload mem[0x30C0+k] = 0xA000+k; Start, Load_En=1, Save_En=0, Load_Id=3 -> reg k = 0xA000+k, reg 0 = 0, Cur_Id = 3, Done at cycle 65.
- Full switch with Save_Id=1, Load_Id=5 -> save area 1 equals the old registers, registers equal area 5, Done at cycle 128, Busy high exactly for cycles 1..127.
- Start pulsed at cycles 10, 100 and 128 during a full switch -> exactly one Done, no extra strobes.
- Reset asserted at cycle 70 of a full switch -> strobes low from cycle 71, state IDLE, Cur_Id unchanged from reset value 0.
- Start with Save_En=0, Load_En=0 -> Done at cycle 1, no memory or register-file writes.

Source files
------------

// File: rtl/ctx_pkg.sv
// ctx_pkg: shared definitions for the context-switch sequencer.
//   ctx_state_e : sequencer states
//   CTX_WORDS   : words per process save area (one per general register)
//   FIRST_REG   : first register streamed (register 0 is hard-wired, never saved)
//   LAST_REG    : last register streamed
package ctx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_SAVE      = 3'd1,
        ST_LOAD      = 3'd2,
        ST_LOAD_TAIL = 3'd3,
        ST_DONE      = 3'd4
    } ctx_state_e;

    localparam int         CTX_WORDS = 64;
    localparam logic [5:0] FIRST_REG = 6'd1;
    localparam logic [5:0] LAST_REG  = 6'd63;

endpackage

// File: rtl/ctx_addr_gen.sv
// ctx_addr_gen: latches the save-area and load-area base addresses when a
// request is accepted and forms the data-memory word address from the
// selected base plus the register index.
//   clk       in   clock
//   srst      in   synchronous active-high reset (clears both bases)
//   latch     in   request accepted this cycle; capture both bases
//   save_id   in   outgoing process id
//   load_id   in   incoming process id
//   addr_en   in   drive an address this cycle (otherwise output is 0)
//   use_load  in   select load base instead of save base
//   idx       in   register index within the save area
//   mem_addr  out  data-memory word address
module ctx_addr_gen #(
    parameter logic [31:0] CTX_BASE = 32'h0000_3000,
    parameter int          ID_W     = 4,
    parameter int          ADDR_W   = 32
) (
    input  logic              clk,
    input  logic              srst,
    input  logic              latch,
    input  logic [ID_W-1:0]   save_id,
    input  logic [ID_W-1:0]   load_id,
    input  logic              addr_en,
    input  logic              use_load,
    input  logic [5:0]        idx,
    output logic [ADDR_W-1:0] mem_addr
);

    logic [ADDR_W-1:0] save_base_reg;
    logic [ADDR_W-1:0] load_base_reg;
    logic [ADDR_W-1:0] save_base_next;
    logic [ADDR_W-1:0] load_base_next;

    // Area p starts at CTX_BASE + p*64; the shift is a concatenation and the
    // sum wraps naturally at ADDR_W bits.
    assign save_base_next = ADDR_W'(CTX_BASE) + ADDR_W'({save_id, 6'b0});
    assign load_base_next = ADDR_W'(CTX_BASE) + ADDR_W'({load_id, 6'b0});

    always_ff @(posedge clk) begin
        if (srst) begin
            save_base_reg <= '0;
            load_base_reg <= '0;
        end else if (latch) begin
            save_base_reg <= save_base_next;
            load_base_reg <= load_base_next;
        end
    end

    always_comb begin
        mem_addr = '0;
        if (addr_en) begin
            mem_addr = (use_load ? load_base_reg : save_base_reg) + ADDR_W'(idx);
        end
    end

endmodule

// File: rtl/ctx_switch_ctrl.sv
// ctx_switch_ctrl: context-switch sequencer. Streams registers 1..63 of the
// outgoing process into its save area, then streams the incoming process's
// save area back into registers 1..63, stalling the CPU meanwhile.
//   Slow_Clock      in   clock
//   Reset           in   synchronous active-high reset
//   Start           in   request pulse, honoured only in IDLE
//   Save_En/Load_En in   enable save / load phase (sampled with Start)
//   Save_Id/Load_Id in   outgoing / incoming process id (sampled with Start)
//   Rf_Read_Sel     out  register-file read select
//   Rf_Read_Data    in   combinational register-file read data
//   Rf_Write_*      out  register-file write strobe, select, data
//   Mem_Addr        out  data-memory word address
//   Mem_Write_*     out  data-memory write strobe, data
//   Mem_Read_Data   in   memory read data, one cycle after Mem_Addr
//   Busy/Stall_Cpu  out  high while SAVE, LOAD or LOAD_TAIL
//   Done            out  one-cycle completion pulse
//   Cur_Id          out  id of the currently loaded process
module ctx_switch_ctrl
    import ctx_pkg::*;
#(
    parameter logic [31:0] CTX_BASE = 32'h0000_3000,
    parameter int          ID_W     = 4,
    parameter int          ADDR_W   = 32
) (
    input  logic              Slow_Clock,
    input  logic              Reset,
    input  logic              Start,
    input  logic              Save_En,
    input  logic              Load_En,
    input  logic [ID_W-1:0]   Save_Id,
    input  logic [ID_W-1:0]   Load_Id,
    output logic [5:0]        Rf_Read_Sel,
    input  logic [31:0]       Rf_Read_Data,
    output logic              Rf_Write_En,
    output logic [5:0]        Rf_Write_Sel,
    output logic [31:0]       Rf_Write_Data,
    output logic [ADDR_W-1:0] Mem_Addr,
    output logic              Mem_Write_En,
    output logic [31:0]       Mem_Write_Data,
    input  logic [31:0]       Mem_Read_Data,
    output logic              Busy,
    output logic              Stall_Cpu,
    output logic              Done,
    output logic [ID_W-1:0]   Cur_Id
);

    ctx_state_e      state_reg, state_next;
    logic [5:0]      idx_reg, idx_next;
    logic            save_en_reg, load_en_reg;
    logic [ID_W-1:0] load_id_reg;
    logic [ID_W-1:0] cur_id_reg;
    logic            busy_reg;
    logic            start_accept;
    logic            addr_en;
    logic            use_load;

    assign start_accept = (state_reg == ST_IDLE) && Start;

    ctx_addr_gen #(
        .CTX_BASE (CTX_BASE),
        .ID_W     (ID_W),
        .ADDR_W   (ADDR_W)
    ) u_addr_gen (
        .clk      (Slow_Clock),
        .srst     (Reset),
        .latch    (start_accept),
        .save_id  (Save_Id),
        .load_id  (Load_Id),
        .addr_en  (addr_en),
        .use_load (use_load),
        .idx      (idx_reg),
        .mem_addr (Mem_Addr)
    );

    // Next-state and index sequencing.
    always_comb begin
        state_next = state_reg;
        idx_next   = idx_reg;
        case (state_reg)
            ST_IDLE: begin
                if (Start) begin
                    idx_next = FIRST_REG;
                    if (Save_En)      state_next = ST_SAVE;
                    else if (Load_En) state_next = ST_LOAD;
                    else              state_next = ST_DONE;
                end
            end
            ST_SAVE: begin
                if (idx_reg == LAST_REG) begin
                    idx_next   = FIRST_REG;
                    state_next = load_en_reg ? ST_LOAD : ST_DONE;
                end else begin
                    idx_next = idx_reg + 6'd1;
                end
            end
            ST_LOAD: begin
                if (idx_reg == LAST_REG) state_next = ST_LOAD_TAIL;
                else                     idx_next   = idx_reg + 6'd1;
            end
            ST_LOAD_TAIL: state_next = ST_DONE;
            ST_DONE:      state_next = ST_IDLE;
            default:      state_next = ST_IDLE;
        endcase
    end

    // Strobes are decoded from the current state and index. During LOAD the
    // memory returns data one cycle late, so each cycle writes the register
    // addressed on the previous cycle; LOAD_TAIL drains register 63.
    always_comb begin
        Rf_Read_Sel    = '0;
        Rf_Write_En    = 1'b0;
        Rf_Write_Sel   = '0;
        Rf_Write_Data  = '0;
        Mem_Write_En   = 1'b0;
        Mem_Write_Data = '0;
        addr_en        = 1'b0;
        use_load       = 1'b0;
        case (state_reg)
            ST_SAVE: begin
                Rf_Read_Sel    = idx_reg;
                addr_en        = 1'b1;
                Mem_Write_En   = 1'b1;
                Mem_Write_Data = Rf_Read_Data;
            end
            ST_LOAD: begin
                addr_en  = 1'b1;
                use_load = 1'b1;
                if (idx_reg > FIRST_REG) begin
                    Rf_Write_En   = 1'b1;
                    Rf_Write_Sel  = idx_reg - 6'd1;
                    Rf_Write_Data = Mem_Read_Data;
                end
            end
            ST_LOAD_TAIL: begin
                Rf_Write_En   = 1'b1;
                Rf_Write_Sel  = LAST_REG;
                Rf_Write_Data = Mem_Read_Data;
            end
            default: ;
        endcase
    end

    always_ff @(posedge Slow_Clock) begin
        if (Reset) begin
            state_reg   <= ST_IDLE;
            idx_reg     <= '0;
            save_en_reg <= 1'b0;
            load_en_reg <= 1'b0;
            load_id_reg <= '0;
            cur_id_reg  <= '0;
            busy_reg    <= 1'b0;
        end else begin
            state_reg <= state_next;
            idx_reg   <= idx_next;
            if (start_accept) begin
                save_en_reg <= Save_En;
                load_en_reg <= Load_En;
                load_id_reg <= Load_Id;
            end
            if (state_reg == ST_DONE && load_en_reg) begin
                cur_id_reg <= load_id_reg;
            end
            busy_reg <= (state_next == ST_SAVE) || (state_next == ST_LOAD) ||
                        (state_next == ST_LOAD_TAIL);
        end
    end

    assign Busy      = busy_reg;
    assign Stall_Cpu = busy_reg;
    assign Done      = (state_reg == ST_DONE);
    assign Cur_Id    = cur_id_reg;

endmodule

// File: tb/tb_ctx_switch_ctrl.sv
// tb_ctx_switch_ctrl: scoreboard bench for ctx_switch_ctrl. Models the
// register file and the save-area memory; each request pushes its expected
// memory writes, register writes and Done cycle, which are popped and
// compared as the DUT produces them.
module tb_ctx_switch_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        start, save_en, load_en;
    logic [3:0]  save_id, load_id;
    logic [5:0]  rf_read_sel;
    logic [31:0] rf_read_data;
    logic        rf_write_en;
    logic [5:0]  rf_write_sel;
    logic [31:0] rf_write_data;
    logic [31:0] mem_addr;
    logic        mem_write_en;
    logic [31:0] mem_write_data;
    logic [31:0] mem_read_data;
    logic        busy, stall_cpu, done;
    logic [3:0]  cur_id;

    always #5 clk = ~clk;

    ctx_switch_ctrl dut (
        .Slow_Clock     (clk),
        .Reset          (rst),
        .Start          (start),
        .Save_En        (save_en),
        .Load_En        (load_en),
        .Save_Id        (save_id),
        .Load_Id        (load_id),
        .Rf_Read_Sel    (rf_read_sel),
        .Rf_Read_Data   (rf_read_data),
        .Rf_Write_En    (rf_write_en),
        .Rf_Write_Sel   (rf_write_sel),
        .Rf_Write_Data  (rf_write_data),
        .Mem_Addr       (mem_addr),
        .Mem_Write_En   (mem_write_en),
        .Mem_Write_Data (mem_write_data),
        .Mem_Read_Data  (mem_read_data),
        .Busy           (busy),
        .Stall_Cpu      (stall_cpu),
        .Done           (done),
        .Cur_Id         (cur_id)
    );

    // Environment models: register file and the 16 save areas at 0x3000.
    logic [31:0] rf_m  [0:63];
    logic [31:0] mem_m [0:1023];

    function automatic bit in_area(input logic [31:0] a);
        return (a >= 32'h3000) && (a < 32'h3400);
    endfunction

    assign rf_read_data = rf_m[rf_read_sel];

    always @(posedge clk) begin
        mem_read_data = in_area(mem_addr) ? mem_m[mem_addr - 32'h3000] : 32'h0;
        if (mem_write_en && in_area(mem_addr)) mem_m[mem_addr - 32'h3000] = mem_write_data;
        if (rf_write_en && rf_write_sel != 6'd0) rf_m[rf_write_sel] = rf_write_data;
    end

    typedef struct {
        logic [31:0] key;
        logic [31:0] data;
        int          cyc;
    } exp_t;

    exp_t mem_q [$];
    exp_t rf_q  [$];
    int   done_q[$];

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One request: push expectations, pulse Start, then watch a bounded
    // window. rst_at > 0 asserts Reset during that cycle; extra pulses Start
    // again at cycles 10, 100 and 128.
    task automatic run_xfer(input bit sv, input bit ld, input logic [3:0] sid,
                            input logic [3:0] lid, input int rst_at, input bit extra);
        int   base, done_cyc, busy_end, end_cyc;
        exp_t e, g;
        bit   exp_busy;
        base     = sv ? 63 : 0;
        done_cyc = base + (ld ? 64 : 0) + 1;
        if (sv) begin
            for (int k = 1; k <= 63; k++) begin
                e.key = 32'h3000 + 32'(sid) * 64 + 32'(k);
                e.data = rf_m[k];
                e.cyc = k;
                if (rst_at == 0 || e.cyc <= rst_at) mem_q.push_back(e);
            end
        end
        if (ld) begin
            for (int k = 1; k <= 63; k++) begin
                e.key = 32'(k);
                e.data = mem_m[32'(lid) * 64 + 32'(k)];
                e.cyc = base + k + 1;
                if (rst_at == 0 || e.cyc <= rst_at) rf_q.push_back(e);
            end
        end
        if (rst_at == 0) done_q.push_back(done_cyc);
        busy_end = (rst_at != 0) ? rst_at + 1 : done_cyc;
        end_cyc  = ((rst_at != 0) ? rst_at : done_cyc) + 3;

        @(negedge clk);
        save_en = sv; load_en = ld; save_id = sid; load_id = lid; start = 1'b1;
        for (int rel = 1; rel <= end_cyc; rel++) begin
            @(negedge clk);
            start = extra && (rel == 10 || rel == 100 || rel == 128);
            rst   = (rst_at != 0) && (rel == rst_at);
            exp_busy = (rel < busy_end);
            check_val("busy", busy, exp_busy);
            check_val("stall", stall_cpu, exp_busy);
            if (mem_write_en) begin
                if (mem_q.size() == 0) check_val("mem_unexpected", mem_q.size(), 1);
                else begin
                    g = mem_q.pop_front();
                    check_val("mem_addr", mem_addr, g.key);
                    check_val("mem_data", mem_write_data, g.data);
                    check_val("mem_cyc", rel, g.cyc);
                end
            end
            if (rf_write_en) begin
                if (rf_q.size() == 0) check_val("rf_unexpected", rf_q.size(), 1);
                else begin
                    g = rf_q.pop_front();
                    check_val("rf_sel", rf_write_sel, g.key);
                    check_val("rf_data", rf_write_data, g.data);
                    check_val("rf_cyc", rel, g.cyc);
                end
            end
            if (done) begin
                if (done_q.size() == 0) check_val("done_unexpected", done_q.size(), 1);
                else check_val("done_cyc", rel, done_q.pop_front());
            end
        end
        start = 1'b0;
        rst   = 1'b0;
        check_val("mem_q_left", mem_q.size(), 0);
        check_val("rf_q_left", rf_q.size(), 0);
        check_val("done_q_left", done_q.size(), 0);
        mem_q.delete();
        rf_q.delete();
        done_q.delete();
        $display("xfer save=%0d load=%0d sid=%0d lid=%0d rst_at=%0d extra=%0d cur_id=%0d",
                 sv, ld, sid, lid, rst_at, extra, cur_id);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; save_en = 1'b0; load_en = 1'b0;
        save_id = '0; load_id = '0;
        for (int i = 0; i < 64; i++)   rf_m[i]  = (i == 0) ? 32'h0 : 32'h100 + 32'(i);
        for (int i = 0; i < 1024; i++) mem_m[i] = 32'hDEAD_0000 | 32'(i);
        for (int k = 1; k < 64; k++) begin
            mem_m[3 * 64 + k] = 32'hA000 + 32'(k);
            mem_m[5 * 64 + k] = 32'h5500_0000 + 32'(k);
            mem_m[6 * 64 + k] = 32'h6600_0000 + 32'(k);
        end
        repeat (3) @(negedge clk);
        check_val("rst_busy", busy, 0);
        check_val("rst_stall", stall_cpu, 0);
        check_val("rst_done", done, 0);
        check_val("rst_cur_id", cur_id, 0);
        check_val("rst_mem_we", mem_write_en, 0);
        check_val("rst_rf_we", rf_write_en, 0);
        check_val("rst_mem_addr", mem_addr, 0);
        rst = 1'b0;
        @(negedge clk);

        // Save-only from the preloaded registers into area 2.
        run_xfer(1'b1, 1'b0, 4'd2, 4'd0, 0, 1'b0);
        check_val("area2_word0", mem_m[2 * 64], 32'hDEAD_0080);
        check_val("area2_word63", mem_m[2 * 64 + 63], 32'h13F);
        check_val("cur_id_after_save", cur_id, 0);

        // Load-only from area 3.
        run_xfer(1'b0, 1'b1, 4'd0, 4'd3, 0, 1'b0);
        check_val("reg0", rf_m[0], 0);
        check_val("reg63_load", rf_m[63], 32'hA03F);
        check_val("cur_id_after_load", cur_id, 3);

        // Full switch 1 -> 5 with ignored Start pulses.
        run_xfer(1'b1, 1'b1, 4'd1, 4'd5, 0, 1'b1);
        check_val("area1_word1", mem_m[64 + 1], 32'hA001);
        check_val("reg1_full", rf_m[1], 32'h5500_0001);
        check_val("cur_id_after_full", cur_id, 5);

        // Full switch 4 -> 6 aborted by Reset in cycle 70.
        run_xfer(1'b1, 1'b1, 4'd4, 4'd6, 70, 1'b0);
        check_val("reg6_partial", rf_m[6], 32'h6600_0006);
        check_val("reg7_untouched", rf_m[7], 32'h5500_0007);
        check_val("cur_id_after_rst", cur_id, 0);

        // Neither phase: Done in cycle 1, no writes.
        run_xfer(1'b0, 1'b0, 4'd7, 4'd8, 0, 1'b0);
        check_val("cur_id_after_none", cur_id, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
